burst_local_bridge: RTL and testbench

- Responder side of the frame-buffer burst interface: accepts wr_burst_*/rd_burst_* requests from the FIFO controller and executes them on the DDR2 PHY local (Avalon-style) interface.
- Sits between the FIFO controller and the DDR2 PHY inside the DDR top, clocked by phy_clk.
- Splits each user burst (1..512 words) into local bursts of at most LOCAL_BURST beats and arbitrates between write and read requests.

---
 rtl/burst_local_bridge_pkg.sv | 15 +
 rtl/burst_chunk_cnt.sv | 51 +++++
 rtl/burst_local_bridge.sv | 150 +++++++++++++++
 tb/tb_burst_local_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_local_bridge_pkg.sv
// Shared types and constants for the burst-to-local-interface bridge.
package burst_local_bridge_pkg;

    localparam int unsigned LocalBurstDflt = 4;
    localparam int unsigned LenW           = 10;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdCmd,
        StRdWait,
        StDone
    } state_e;

endpackage

// File: rtl/burst_chunk_cnt.sv
// Splits a user burst into local chunks: tracks words issued and the base of the current chunk.
module burst_chunk_cnt
    import burst_local_bridge_pkg::*;
#(
    parameter int unsigned LOCAL_BURST = LocalBurstDflt
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic [LenW-1:0] len,
    input  logic            step_beat,
    input  logic            step_chunk,
    output logic [LenW-1:0] issued,
    output logic [3:0]      chunk_size,
    output logic            first_beat,
    output logic            last_beat,
    output logic            last_chunk
);

    logic [LenW-1:0] issued_q, base_q;
    logic [LenW-1:0] remaining, chunk_w, issued_inc;

    // Chunk size is derived from the chunk base so it stays constant across the chunk's beats.
    assign remaining  = len - base_q;
    assign chunk_w    = (remaining > LenW'(LOCAL_BURST)) ? LenW'(LOCAL_BURST) : remaining;
    assign chunk_size = chunk_w[3:0];
    assign issued_inc = issued_q + LenW'(1);
    assign first_beat = (issued_q == base_q);
    assign last_beat  = (issued_inc == len);
    assign last_chunk = (remaining <= LenW'(LOCAL_BURST));
    assign issued     = issued_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            base_q   <= '0;
        end else if (clear) begin
            issued_q <= '0;
            base_q   <= '0;
        end else if (step_beat) begin
            issued_q <= issued_inc;
            if (issued_inc == base_q + chunk_w) begin
                base_q <= issued_inc;
            end
        end else if (step_chunk) begin
            issued_q <= issued_q + chunk_w;
            base_q   <= base_q + chunk_w;
        end
    end

endmodule

// File: rtl/burst_local_bridge.sv
// Executes user write/read bursts on the DDR2 PHY local interface, chunked to LOCAL_BURST beats
// with round-robin arbitration between write and read requests.
module burst_local_bridge
    import burst_local_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LOCAL_BURST = LocalBurstDflt
) (
    input  logic                phy_clk,
    input  logic                rst_n,
    input  logic                local_init_done,
    input  logic                wr_burst_req,
    input  logic [ADDR_W-1:0]   wr_burst_addr,
    input  logic [LenW-1:0]     wr_burst_len,
    output logic                wr_burst_data_req,
    input  logic [DATA_W-1:0]   wr_burst_data,
    output logic                wr_burst_finish,
    input  logic                rd_burst_req,
    input  logic [ADDR_W-1:0]   rd_burst_addr,
    input  logic [LenW-1:0]     rd_burst_len,
    output logic                rd_burst_data_valid,
    output logic [DATA_W-1:0]   rd_burst_data,
    output logic                rd_burst_finish,
    input  logic                local_ready,
    output logic [ADDR_W-1:0]   local_address,
    output logic [3:0]          local_size,
    output logic                local_burstbegin,
    output logic                local_write_req,
    output logic                local_read_req,
    output logic [DATA_W-1:0]   local_wdata,
    output logic [DATA_W/8-1:0] local_be,
    input  logic [DATA_W-1:0]   local_rdata,
    input  logic                local_rdata_valid
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LenW-1:0]   len_q, returned_q, issued, req_len;
    logic              cur_wr_q, last_wr_q, wr_finish_q, rd_finish_q, rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [3:0]        chunk_size;
    logic              first_beat, last_beat, last_chunk;
    logic              accept, pick_wr, step_beat, step_chunk, in_wr, in_rd_cmd, rd_active;
    logic              rd_beat;

    assign in_wr      = (state_q == StWr);
    assign in_rd_cmd  = (state_q == StRdCmd);
    assign rd_active  = in_rd_cmd || (state_q == StRdWait);
    assign rd_beat    = local_rdata_valid && rd_active;
    assign accept     = (state_q == StIdle) && local_init_done && (wr_burst_req || rd_burst_req);
    // Write wins unless both are pending and write was the last one served.
    assign pick_wr    = wr_burst_req && (!rd_burst_req || !last_wr_q);
    assign req_len    = pick_wr ? wr_burst_len : rd_burst_len;
    assign step_beat  = in_wr && local_ready;
    assign step_chunk = in_rd_cmd && local_ready;

    burst_chunk_cnt #(
        .LOCAL_BURST(LOCAL_BURST)
    ) u_chunk_cnt (
        .clk        (phy_clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .len        (len_q),
        .step_beat  (step_beat),
        .step_chunk (step_chunk),
        .issued     (issued),
        .chunk_size (chunk_size),
        .first_beat (first_beat),
        .last_beat  (last_beat),
        .last_chunk (last_chunk)
    );

    assign wr_burst_data_req   = step_beat;
    assign wr_burst_finish     = wr_finish_q;
    assign rd_burst_finish     = rd_finish_q;
    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_data       = rd_data_q;
    assign local_write_req     = in_wr;
    assign local_read_req      = in_rd_cmd;
    assign local_wdata         = in_wr ? wr_burst_data : '0;
    assign local_burstbegin    = (in_wr && first_beat) || in_rd_cmd;
    assign local_address       = local_burstbegin ? addr_q + ADDR_W'(issued) : '0;
    assign local_size          = (in_wr || in_rd_cmd) ? chunk_size : '0;
    assign local_be            = '1;

    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            returned_q  <= '0;
            cur_wr_q    <= 1'b0;
            last_wr_q   <= 1'b0;
            wr_finish_q <= 1'b0;
            rd_finish_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_finish_q <= 1'b0;
            rd_finish_q <= 1'b0;
            rd_valid_q  <= rd_beat;
            if (rd_beat) begin
                rd_data_q  <= local_rdata;
                returned_q <= returned_q + LenW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cur_wr_q   <= pick_wr;
                        addr_q     <= pick_wr ? wr_burst_addr : rd_burst_addr;
                        len_q      <= req_len;
                        returned_q <= '0;
                        if (req_len == '0) begin
                            state_q     <= StDone;
                            wr_finish_q <= pick_wr;
                            rd_finish_q <= !pick_wr;
                        end else begin
                            state_q <= pick_wr ? StWr : StRdCmd;
                        end
                    end
                end
                StWr: begin
                    if (step_beat && last_beat) begin
                        state_q     <= StDone;
                        wr_finish_q <= 1'b1;
                    end
                end
                StRdCmd: begin
                    if (step_chunk && last_chunk) begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    // The last beat is already on rd_burst_data when the count reaches len.
                    if (returned_q == len_q) begin
                        state_q     <= StDone;
                        rd_finish_q <= 1'b1;
                    end
                end
                StDone: begin
                    last_wr_q <= cur_wr_q;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_local_bridge.sv
// Directed bench for burst_local_bridge: table of single bursts plus arbitration and reset cases.
module tb_burst_local_bridge;
    import burst_local_bridge_pkg::*;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 32;

    logic                phy_clk = 1'b0;
    logic                rst_n;
    logic                local_init_done;
    logic                wr_burst_req;
    logic [ADDR_W-1:0]   wr_burst_addr;
    logic [9:0]          wr_burst_len;
    logic                wr_burst_data_req;
    logic [DATA_W-1:0]   wr_burst_data;
    logic                wr_burst_finish;
    logic                rd_burst_req;
    logic [ADDR_W-1:0]   rd_burst_addr;
    logic [9:0]          rd_burst_len;
    logic                rd_burst_data_valid;
    logic [DATA_W-1:0]   rd_burst_data;
    logic                rd_burst_finish;
    logic                local_ready;
    logic [ADDR_W-1:0]   local_address;
    logic [3:0]          local_size;
    logic                local_burstbegin;
    logic                local_write_req;
    logic                local_read_req;
    logic [DATA_W-1:0]   local_wdata;
    logic [DATA_W/8-1:0] local_be;
    logic [DATA_W-1:0]   local_rdata;
    logic                local_rdata_valid;

    burst_local_bridge #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .LOCAL_BURST (4)
    ) dut (
        .phy_clk             (phy_clk),
        .rst_n               (rst_n),
        .local_init_done     (local_init_done),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .local_ready         (local_ready),
        .local_address       (local_address),
        .local_size          (local_size),
        .local_burstbegin    (local_burstbegin),
        .local_write_req     (local_write_req),
        .local_read_req      (local_read_req),
        .local_wdata         (local_wdata),
        .local_be            (local_be),
        .local_rdata         (local_rdata),
        .local_rdata_valid   (local_rdata_valid)
    );

    always #5 phy_clk = ~phy_clk;

    int cyc = 0;
    always @(posedge phy_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Per-run observations
    int wr_beats, rd_beats, begins, cmds, order;
    int wr_fin, rd_fin, last_wb, last_rv, start_cyc;

    typedef struct {
        bit              is_wr;
        logic [24:0]     addr;
        int              len;
        bit              tog;
        int              exp_begins;
        int              exp_cmds;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int min4(input int r);
        return (r > 4) ? 4 : r;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {wr_burst_data_req, wr_burst_finish, rd_burst_data_valid,
                              rd_burst_finish, local_burstbegin, local_write_req,
                              local_read_req}, 0);
        check({tag, "_addr"}, local_address, 0);
        check({tag, "_size"}, local_size, 0);
        check({tag, "_wdata"}, local_wdata, 0);
        check({tag, "_rdata"}, rd_burst_data, 0);
        check({tag, "_be"}, local_be, 4'hF);
    endtask

    task automatic run(input bit do_wr, input logic [24:0] waddr, input int wlen,
                       input bit do_rd, input logic [24:0] raddr, input int rlen,
                       input bit tog);
        logic [ADDR_W-1:0] rq[$];
        bit wr_busy, rd_busy, prev_rv, phase;
        int rcmd, guard;
        wr_busy = do_wr; rd_busy = do_rd; prev_rv = 1'b0; phase = 1'b0;
        rcmd = 0; guard = 0;
        wr_beats = 0; rd_beats = 0; begins = 0; cmds = 0; order = 0;
        wr_fin = -1; rd_fin = -1; last_wb = -1; last_rv = -1;
        @(negedge phy_clk);
        wr_burst_req = do_wr; wr_burst_addr = waddr; wr_burst_len = 10'(wlen);
        rd_burst_req = do_rd; rd_burst_addr = raddr; rd_burst_len = 10'(rlen);
        start_cyc = cyc;
        while ((wr_busy || rd_busy) && guard < 3000) begin
            guard++;
            local_ready = tog ? phase : 1'b1;
            phase = ~phase;
            wr_burst_data = 32'hA500_0000 + 32'(wr_beats);
            local_rdata_valid = (rq.size() > 0);
            local_rdata = 32'h0;
            if (local_rdata_valid) local_rdata = 32'h5A00_0000 ^ 32'(rq[0]);
            #1;
            if (do_rd) check("rd_valid_lag", rd_burst_data_valid, prev_rv);
            prev_rv = local_rdata_valid;
            if (local_rdata_valid) void'(rq.pop_front());
            if (wr_burst_data_req) begin
                check("wr_req", local_write_req, 1);
                check("wdata", local_wdata, 32'hA500_0000 + 32'(wr_beats));
                if (local_burstbegin) begin
                    begins++;
                    check("waddr", local_address, ADDR_W'(waddr + 25'(wr_beats)));
                    check("wsize", local_size, min4(wlen - wr_beats));
                end
                wr_beats++;
                last_wb = cyc;
            end
            if (local_read_req && local_ready) begin
                cmds++;
                if (local_burstbegin) begins++;
                check("raddr", local_address, ADDR_W'(raddr + 25'(rcmd)));
                check("rsize", local_size, min4(rlen - rcmd));
                for (int k = 0; k < int'(local_size); k++) begin
                    rq.push_back(ADDR_W'(local_address + 25'(k)));
                end
                rcmd += int'(local_size);
            end
            if (rd_burst_data_valid) begin
                check("rdata", rd_burst_data,
                      32'h5A00_0000 ^ 32'(ADDR_W'(raddr + 25'(rd_beats))));
                rd_beats++;
                last_rv = cyc;
            end
            if (wr_burst_finish && wr_busy) begin
                if (order == 0) order = 1;
                wr_fin = cyc; wr_busy = 1'b0; wr_burst_req = 1'b0;
            end
            if (rd_burst_finish && rd_busy) begin
                if (order == 0) order = 2;
                rd_fin = cyc; rd_busy = 1'b0; rd_burst_req = 1'b0;
            end
            @(negedge phy_clk);
        end
        if (guard >= 3000) check("timeout", 1, 0);
        local_ready = 1'b0;
        local_rdata_valid = 1'b0;
        #1;
        check("finish_width", {wr_burst_finish, rd_burst_finish}, 0);
    endtask

    initial begin
        int n, seen;
        rst_n = 1'b0; local_init_done = 1'b1;
        wr_burst_req = 0; wr_burst_addr = '0; wr_burst_len = '0; wr_burst_data = '0;
        rd_burst_req = 0; rd_burst_addr = '0; rd_burst_len = '0;
        local_ready = 1'b1; local_rdata = 32'hDEAD_BEEF; local_rdata_valid = 1'b1;
        repeat (3) @(negedge phy_clk);
        #1;
        check_quiet("reset");
        local_ready = 1'b0; local_rdata_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge phy_clk);

        // Simultaneous requests: write first after reset, and again after the read
        run(1, 25'h300, 4, 1, 25'h400, 4, 0);
        check("pair1_order", order, 1);
        check("pair1_wbeats", wr_beats, 4);
        check("pair1_rbeats", rd_beats, 4);
        run(1, 25'h500, 4, 1, 25'h600, 4, 0);
        check("pair2_order", order, 1);
        check("pair2_rbeats", rd_beats, 4);

        vecs[0] = '{1'b1, 25'h0000100,   8, 1'b0,   2,   0};
        vecs[1] = '{1'b0, 25'h0000010,   6, 1'b0,   2,   2};
        vecs[2] = '{1'b1, 25'h0002000, 256, 1'b1,  64,   0};
        vecs[3] = '{1'b0, 25'h1FFFFFE,   5, 1'b1,   2,   2};
        vecs[4] = '{1'b1, 25'h0000055,   1, 1'b0,   1,   0};
        vecs[5] = '{1'b0, 25'h0000040,   0, 1'b0,   0,   0};
        vecs[6] = '{1'b1, 25'h0000080,   0, 1'b0,   0,   0};
        vecs[7] = '{1'b0, 25'h0001000, 512, 1'b0, 128, 128};

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) begin
                run(1, vecs[i].addr, vecs[i].len, 0, 25'h0, 0, vecs[i].tog);
                check("v_wbeats", wr_beats, vecs[i].len);
                check("v_wfin", wr_fin - ((vecs[i].len == 0) ? start_cyc : last_wb), 1);
            end else begin
                run(0, 25'h0, 0, 1, vecs[i].addr, vecs[i].len, vecs[i].tog);
                check("v_rbeats", rd_beats, vecs[i].len);
                check("v_rfin", rd_fin - ((vecs[i].len == 0) ? start_cyc : last_rv), 1);
            end
            check("v_begins", begins, vecs[i].exp_begins);
            check("v_cmds", cmds, vecs[i].exp_cmds);
        end

        // Reset asserted on the third write beat
        @(negedge phy_clk);
        wr_burst_req = 1'b1; wr_burst_addr = 25'h100; wr_burst_len = 10'd8;
        local_ready = 1'b1;
        n = 0;
        for (int g = 0; g < 20 && n < 3; g++) begin
            wr_burst_data = 32'hA500_0000 + 32'(n);
            #1;
            if (wr_burst_data_req) n++;
            if (n < 3) @(negedge phy_clk);
        end
        check("midwr_beats", n, 3);
        rst_n = 1'b0; local_init_done = 1'b0;
        #1;
        check_quiet("midwr_reset");
        repeat (2) @(negedge phy_clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge phy_clk);
            #1;
            if (local_write_req || wr_burst_data_req || local_read_req) seen++;
        end
        check("no_serve_before_init", seen, 0);
        wr_burst_req = 1'b0; local_ready = 1'b0;
        local_init_done = 1'b1;
        run(1, 25'h100, 8, 0, 25'h0, 0, 0);
        check("post_init_wbeats", wr_beats, 8);
        check("post_init_begins", begins, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
